line_mem_arbiter: RTL

- Shares the single line-granular data memory (128-bit lines, 8-bit line address, valid/ready handshake, multi-cycle latency) between the instruction-cache refill port and the data-cache refill/write-back port.
- Arbitrates between three request types: I-read, D-write and D-read.
- Latches the winning request's address and data, drives the memory handshake, and returns the line and a one-cycle ready pulse to the winner.
- Sits between the two cache controllers and the data memory.

---
 rtl/line_mem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares one line-granular data memory between the
// I-cache refill port and the D-cache refill/write-back port. Round-robin
// between I and D. On the D side a write-back always beats a read. All
// outputs are registered.
module line_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_r_valid,
    input  logic [ADDR_W-1:0] i_r_addr,
    output logic [LINE_W-1:0] i_r_data,
    output logic              i_r_ready,
    input  logic              d_r_valid,
    input  logic [ADDR_W-1:0] d_r_addr,
    output logic [LINE_W-1:0] d_r_data,
    output logic              d_r_ready,
    input  logic              d_w_valid,
    input  logic [ADDR_W-1:0] d_w_addr,
    input  logic [LINE_W-1:0] d_w_data,
    output logic              d_w_ready,
    output logic              m_r_valid,
    output logic              m_w_valid,
    output logic [ADDR_W-1:0] m_r_addr,
    output logic [ADDR_W-1:0] m_w_addr,
    output logic [LINE_W-1:0] m_w_data,
    input  logic [LINE_W-1:0] m_r_data,
    input  logic              m_r_ready,
    input  logic              m_w_ready,
    output logic [CNT_W-1:0]  i_cnt,
    output logic [CNT_W-1:0]  d_r_cnt,
    output logic [CNT_W-1:0]  d_w_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_WR,
        D_RD,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              grant_i;

    logic              m_r_valid_d, m_w_valid_d;
    logic [ADDR_W-1:0] m_r_addr_d, m_w_addr_d;
    logic [LINE_W-1:0] m_w_data_d;
    logic [LINE_W-1:0] i_r_data_d, d_r_data_d;
    logic              i_r_ready_d, d_r_ready_d, d_w_ready_d;
    logic [CNT_W-1:0]  i_cnt_d, d_r_cnt_d, d_w_cnt_d;

    // I wins when it is the only requester or when the pointer favours it
    assign grant_i = i_r_valid && (!(d_w_valid || d_r_valid) || !rr_q);

    // Next-state and next-output decode; every register holds by default and
    // the ready pulses default low so they last exactly one cycle
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        m_r_valid_d = m_r_valid;
        m_w_valid_d = m_w_valid;
        m_r_addr_d  = m_r_addr;
        m_w_addr_d  = m_w_addr;
        m_w_data_d  = m_w_data;
        i_r_data_d  = i_r_data;
        d_r_data_d  = d_r_data;
        i_r_ready_d = 1'b0;
        d_r_ready_d = 1'b0;
        d_w_ready_d = 1'b0;
        i_cnt_d     = i_cnt;
        d_r_cnt_d   = d_r_cnt;
        d_w_cnt_d   = d_w_cnt;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    m_r_addr_d  = i_r_addr;
                    m_r_valid_d = 1'b1;
                    rr_d        = 1'b1;
                    state_d     = I_RD;
                end else if (d_w_valid) begin
                    m_w_addr_d  = d_w_addr;
                    m_w_data_d  = d_w_data;
                    m_w_valid_d = 1'b1;
                    rr_d        = 1'b0;
                    state_d     = D_WR;
                end else if (d_r_valid) begin
                    m_r_addr_d  = d_r_addr;
                    m_r_valid_d = 1'b1;
                    rr_d        = 1'b0;
                    state_d     = D_RD;
                end
            end
            I_RD: begin
                if (m_r_ready) begin
                    m_r_valid_d = 1'b0;
                    i_r_data_d  = m_r_data;
                    i_r_ready_d = 1'b1;
                    i_cnt_d     = i_cnt + CNT_W'(1);
                    state_d     = RESP;
                end
            end
            D_RD: begin
                if (m_r_ready) begin
                    m_r_valid_d = 1'b0;
                    d_r_data_d  = m_r_data;
                    d_r_ready_d = 1'b1;
                    d_r_cnt_d   = d_r_cnt + CNT_W'(1);
                    state_d     = RESP;
                end
            end
            D_WR: begin
                if (m_w_ready) begin
                    m_w_valid_d = 1'b0;
                    d_w_ready_d = 1'b1;
                    d_w_cnt_d   = d_w_cnt + CNT_W'(1);
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            m_r_valid <= 1'b0;
            m_w_valid <= 1'b0;
            m_r_addr  <= '0;
            m_w_addr  <= '0;
            m_w_data  <= '0;
            i_r_data  <= '0;
            d_r_data  <= '0;
            i_r_ready <= 1'b0;
            d_r_ready <= 1'b0;
            d_w_ready <= 1'b0;
            i_cnt     <= '0;
            d_r_cnt   <= '0;
            d_w_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            m_r_valid <= m_r_valid_d;
            m_w_valid <= m_w_valid_d;
            m_r_addr  <= m_r_addr_d;
            m_w_addr  <= m_w_addr_d;
            m_w_data  <= m_w_data_d;
            i_r_data  <= i_r_data_d;
            d_r_data  <= d_r_data_d;
            i_r_ready <= i_r_ready_d;
            d_r_ready <= d_r_ready_d;
            d_w_ready <= d_w_ready_d;
            i_cnt     <= i_cnt_d;
            d_r_cnt   <= d_r_cnt_d;
            d_w_cnt   <= d_w_cnt_d;
        end
    end

endmodule
